// File: rtl/traffic_pkg.sv
// Shared traffic definitions: vehicle light encodings and pedestrian FSM states.
package traffic_pkg;

    localparam int unsigned N_XING = 4;
    localparam int unsigned TL_W   = 3;

    localparam logic [TL_W-1:0] TL_RED    = 3'b100;
    localparam logic [TL_W-1:0] TL_YELLOW = 3'b010;
    localparam logic [TL_W-1:0] TL_GREEN  = 3'b001;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WALK  = 2'd1,
        FLASH = 2'd2
    } pru_state_t;

endpackage

// File: rtl/pru_debounce.sv
// One push-button: 2-flop synchroniser, stability counter, debounced level and
// a registered one-cycle pulse on each debounced rising edge.
module pru_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic rise
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          level_q, level_d;
    logic          rise_q, rise_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Count consecutive disagreeing samples; any agreeing sample restarts the count.
    always_comb begin
        sync1_d = btn;
        sync2_d = sync1_q;
        level_d = level_q;
        cnt_d   = '0;
        rise_d  = 1'b0;
        if (sync2_q != level_q) begin
            if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                level_d = ~level_q;
                rise_d  = ~level_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            cnt_q   <= cnt_d;
        end
    end

    assign rise = rise_q;

endmodule

// File: rtl/pedestrian_request_unit.sv
// Pedestrian front end: debounced button requests, grant capture, walk/flash lamp
// sequence and red-light cross-check. Define PRU_TIMEOUT_EN to build request age timeouts.
module pedestrian_request_unit
    import traffic_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned WALK_CYCLES     = 20,
    parameter int unsigned FLASH_CYCLES    = 10,
    parameter int unsigned FLASH_PERIOD    = 2,
    parameter int unsigned MAX_WAIT        = 100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  btn,
    input  logic [2:0]  traffic_light,
    input  logic        pedestrian_grant,
    output logic [3:0]  pedestrian,
    output logic [3:0]  served,
    output logic        walk_lamp,
    output logic        flash_lamp,
    output logic        busy,
    output logic        conflict,
    output logic        wait_timeout
);

    localparam int unsigned PH_MAX = (WALK_CYCLES > FLASH_CYCLES) ? WALK_CYCLES : FLASH_CYCLES;
    localparam int unsigned PCW    = $clog2(PH_MAX + 1);
    localparam int unsigned FPW    = $clog2(FLASH_PERIOD + 1);

    pru_state_t          state_q, state_d;
    logic [PCW-1:0]      ph_cnt_q, ph_cnt_d;
    logic [FPW-1:0]      fp_cnt_q, fp_cnt_d;
    logic [N_XING-1:0]   pedestrian_q, pedestrian_d;
    logic [N_XING-1:0]   served_q, served_d;
    logic                walk_q, walk_d;
    logic                flash_q, flash_d;
    logic                busy_q, busy_d;
    logic                conflict_q, conflict_d;
    logic [N_XING-1:0]   rise;
    logic                capture;

    for (genvar i = 0; i < N_XING; i++) begin : g_db
        pru_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clk (clk),
            .rst (rst),
            .btn (btn[i]),
            .rise(rise[i])
        );
    end

    assign capture = (state_q == IDLE) && pedestrian_grant && (pedestrian_q != '0);

    // Next state and registered lamp outputs; a rise during capture stays pending.
    always_comb begin
        state_d      = state_q;
        ph_cnt_d     = ph_cnt_q;
        fp_cnt_d     = fp_cnt_q;
        served_d     = served_q;
        pedestrian_d = pedestrian_q | rise;
        walk_d       = 1'b0;
        flash_d      = 1'b0;
        busy_d       = 1'b0;
        conflict_d   = conflict_q | ((state_q != IDLE) && (traffic_light != TL_RED));
        unique case (state_q)
            IDLE: begin
                if (capture) begin
                    served_d     = pedestrian_q;
                    pedestrian_d = rise;
                    state_d      = WALK;
                    ph_cnt_d     = '0;
                    walk_d       = 1'b1;
                    busy_d       = 1'b1;
                end
            end
            WALK: begin
                busy_d = 1'b1;
                if (ph_cnt_q == PCW'(WALK_CYCLES - 1)) begin
                    state_d  = FLASH;
                    ph_cnt_d = '0;
                    fp_cnt_d = '0;
                    flash_d  = 1'b1;
                end else begin
                    ph_cnt_d = ph_cnt_q + PCW'(1);
                    walk_d   = 1'b1;
                end
            end
            FLASH: begin
                if (ph_cnt_q == PCW'(FLASH_CYCLES - 1)) begin
                    state_d  = IDLE;
                    ph_cnt_d = '0;
                    fp_cnt_d = '0;
                    served_d = '0;
                end else begin
                    busy_d   = 1'b1;
                    ph_cnt_d = ph_cnt_q + PCW'(1);
                    if (fp_cnt_q == FPW'(FLASH_PERIOD - 1)) begin
                        fp_cnt_d = '0;
                        flash_d  = ~flash_q;
                    end else begin
                        fp_cnt_d = fp_cnt_q + FPW'(1);
                        flash_d  = flash_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            ph_cnt_q     <= '0;
            fp_cnt_q     <= '0;
            pedestrian_q <= '0;
            served_q     <= '0;
            walk_q       <= 1'b0;
            flash_q      <= 1'b0;
            busy_q       <= 1'b0;
            conflict_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            ph_cnt_q     <= ph_cnt_d;
            fp_cnt_q     <= fp_cnt_d;
            pedestrian_q <= pedestrian_d;
            served_q     <= served_d;
            walk_q       <= walk_d;
            flash_q      <= flash_d;
            busy_q       <= busy_d;
            conflict_q   <= conflict_d;
        end
    end

`ifdef PRU_TIMEOUT_EN
    localparam int unsigned AW = $clog2(MAX_WAIT + 1);

    logic [N_XING-1:0][AW-1:0] age_q, age_d;
    logic                      timeout_q, timeout_d;

    // Per-crossing saturating age while pending; serving a crossing clears its age.
    always_comb begin
        timeout_d = timeout_q;
        age_d     = '0;
        for (int i = 0; i < N_XING; i++) begin
            if (pedestrian_q[i] && !capture) begin
                age_d[i] = (age_q[i] == AW'(MAX_WAIT)) ? age_q[i] : age_q[i] + AW'(1);
            end
            if (age_d[i] == AW'(MAX_WAIT)) begin
                timeout_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            age_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            age_q     <= age_d;
            timeout_q <= timeout_d;
        end
    end

    assign wait_timeout = timeout_q;
`else
    // MAX_WAIT only matters when the age counters are built.
    logic unused_max_wait;
    assign unused_max_wait = ^32'(MAX_WAIT);
    assign wait_timeout    = 1'b0;
`endif

    assign pedestrian = pedestrian_q;
    assign served     = served_q;
    assign walk_lamp  = walk_q;
    assign flash_lamp = flash_q;
    assign busy       = busy_q;
    assign conflict   = conflict_q;

endmodule

// File: tb/tb_pedestrian_request_unit.sv
// Bench for pedestrian_request_unit: behavioural request/sequence model checked every
// cycle, plus directed literal checks of reset, debounce, service, conflict and timeout.
module tb_pedestrian_request_unit;
    import traffic_pkg::*;

    localparam int unsigned DEB = 4;
    localparam int unsigned W   = 6;
    localparam int unsigned F   = 4;
    localparam int unsigned P   = 2;
    localparam int unsigned MW  = 12;

`ifdef PRU_TIMEOUT_EN
    localparam logic EXP_TO = 1'b1;
`else
    localparam logic EXP_TO = 1'b0;
`endif

    logic       clk   = 1'b0;
    logic       rst   = 1'b0;
    logic [3:0] btn   = 4'h0;
    logic [2:0] tl    = TL_RED;
    logic       grant = 1'b0;

    logic [3:0] pedestrian, served;
    logic       walk_lamp, flash_lamp, busy, conflict, wait_timeout;

    always #5 clk = ~clk;

    pedestrian_request_unit #(
        .DEBOUNCE_CYCLES(DEB),
        .WALK_CYCLES    (W),
        .FLASH_CYCLES   (F),
        .FLASH_PERIOD   (P),
        .MAX_WAIT       (MW)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .btn             (btn),
        .traffic_light   (tl),
        .pedestrian_grant(grant),
        .pedestrian      (pedestrian),
        .served          (served),
        .walk_lamp       (walk_lamp),
        .flash_lamp      (flash_lamp),
        .busy            (busy),
        .conflict        (conflict),
        .wait_timeout    (wait_timeout)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: raw button history, debounced levels, pending set, sequence position t
    // (t=1..W walk, W+1..W+F flash, 0 idle).
    logic [3:0] hist [0:DEB+1];
    logic [3:0] m_level, m_rise_prev, m_ped, m_served, m_flip;
    logic       m_conflict, m_timeout, m_cap, m_differ;
    int         m_t;
    int         m_age [0:3];

    task automatic model_reset();
        for (int k = 0; k <= int'(DEB) + 1; k++) hist[k] = 4'h0;
        m_level = 4'h0; m_rise_prev = 4'h0; m_ped = 4'h0; m_served = 4'h0;
        m_conflict = 1'b0; m_timeout = 1'b0; m_t = 0;
        for (int i = 0; i < 4; i++) m_age[i] = 0;
    endtask

    always @(posedge clk) begin
        if (!rst) begin
            model_reset();
        end else begin
            for (int k = int'(DEB) + 1; k > 0; k--) hist[k] = hist[k-1];
            hist[0] = btn;
            m_cap = (m_t == 0) && grant && (m_ped != 4'h0);
            if (m_t > 0 && tl != TL_RED) m_conflict = 1'b1;
            if (m_cap) begin
                m_served = m_ped;
                m_ped    = m_rise_prev;
                m_t      = 1;
            end else begin
                m_ped = m_ped | m_rise_prev;
                if (m_t > 0) begin
                    m_t++;
                    if (m_t > int'(W + F)) begin
                        m_t      = 0;
                        m_served = 4'h0;
                    end
                end
            end
            // A button flips once its synchronised samples all disagreed for DEB edges.
            for (int i = 0; i < 4; i++) begin
                m_differ = 1'b1;
                for (int k = 2; k <= int'(DEB) + 1; k++)
                    if (hist[k][i] == m_level[i]) m_differ = 1'b0;
                m_flip[i] = m_differ;
            end
            m_rise_prev = m_flip & ~m_level;
            m_level     = m_level ^ m_flip;
            for (int i = 0; i < 4; i++) begin
                m_age[i] = m_ped[i] ? m_age[i] + 1 : 0;
                if (EXP_TO && m_age[i] >= int'(MW) + 1) m_timeout = 1'b1;
            end
        end
        #1;
        check("pedestrian", 32'(pedestrian), 32'(m_ped));
        check("served", 32'(served), 32'(m_served));
        check("walk_lamp", 32'(walk_lamp), 32'(m_t >= 1 && m_t <= int'(W)));
        check("flash_lamp", 32'(flash_lamp),
              32'(m_t > int'(W) && (((m_t - int'(W) - 1) / int'(P)) % 2 == 0)));
        check("busy", 32'(busy), 32'(m_t > 0));
        check("conflict", 32'(conflict), 32'(m_conflict));
        check("wait_timeout", 32'(wait_timeout), 32'(m_timeout));
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ped"}, 32'(pedestrian), 32'h0);
        check({tag, "_served"}, 32'(served), 32'h0);
        check({tag, "_lamps"}, 32'({walk_lamp, flash_lamp, busy}), 32'h0);
        check({tag, "_flags"}, 32'({conflict, wait_timeout}), 32'h0);
    endtask

    initial begin
        model_reset();
        // Reset held with all buttons pressed
        rst = 1'b0; btn = 4'hF;
        cyc(3);
        check_all_zero("reset");
        rst = 1'b1;
        cyc(3);
        check("ped_before_debounce", 32'(pedestrian), 32'h0);
        btn = 4'h0;
        cyc(10);

        // Short glitch is rejected
        btn = 4'b0001; cyc(3); btn = 4'h0; cyc(10);
        check("glitch_rejected", 32'(pedestrian), 32'h0);

        // 5-cycle press on crossings 0 and 2: set 7 cycles after the press
        btn = 4'b0101; cyc(5); btn = 4'h0;
        cyc(1);
        check("ped_at_6", 32'(pedestrian), 32'h0);
        cyc(1);
        check("ped_at_7", 32'(pedestrian), 32'h5);
        cyc(8);

        // Service
        grant = 1'b1; cyc(1); grant = 1'b0;
        check("svc_served", 32'(served), 32'h5);
        check("svc_ped_clear", 32'(pedestrian), 32'h0);
        check("svc_walk_busy", 32'({walk_lamp, busy}), 32'h3);
        cyc(5);
        check("walk_6th", 32'({walk_lamp, flash_lamp}), 32'h2);
        cyc(1); check("flash_1", 32'({walk_lamp, flash_lamp}), 32'h1);
        cyc(1); check("flash_2", 32'(flash_lamp), 32'h1);
        cyc(1); check("flash_3", 32'(flash_lamp), 32'h0);
        cyc(1); check("flash_4", 32'({flash_lamp, busy}), 32'h1);
        cyc(1); check("svc_done", 32'({served, flash_lamp, busy}), 32'h0);

        // Grant with nothing pending is ignored
        grant = 1'b1; cyc(1); grant = 1'b0;
        check("empty_grant", 32'({walk_lamp, busy}), 32'h0);
        cyc(1);

        // Crossing 1 served; crossing 3 pressed during WALK, GREEN during FLASH
        btn = 4'b0010; cyc(5); btn = 4'h0; cyc(2);
        check("ped_b1", 32'(pedestrian), 32'h2);
        grant = 1'b1; cyc(1); grant = 1'b0;
        btn = 4'b1000; cyc(5); btn = 4'h0; cyc(1);
        tl = TL_GREEN; grant = 1'b1; cyc(1); grant = 1'b0; tl = TL_RED;
        check("ped_b3_pending", 32'(pedestrian), 32'h8);
        check("served_b1", 32'(served), 32'h2);
        check("conflict_set", 32'(conflict), 32'h1);
        cyc(3);
        check("idle_after_b1", 32'({busy, served}), 32'h0);
        check("conflict_sticky", 32'(conflict), 32'h1);
        check("ped_b3_still", 32'(pedestrian), 32'h8);

        // Button edge landing on the capture cycle stays pending
        btn = 4'b0100; cyc(5); btn = 4'h0; cyc(1);
        grant = 1'b1; cyc(1); grant = 1'b0;
        check("coincide_served", 32'(served), 32'h8);
        check("coincide_ped", 32'(pedestrian), 32'h4);
        cyc(10);
        check("b2_waiting", 32'({busy, pedestrian}), 32'h4);

        // Age of crossing 2 passes MAX_WAIT
        cyc(5);
        check("wait_timeout", 32'(wait_timeout), 32'(EXP_TO));

        // Mid-sequence reset
        grant = 1'b1; cyc(1); grant = 1'b0; cyc(2);
        check("mid_busy", 32'(busy), 32'h1);
        rst = 1'b0; #1;
        check_all_zero("mid_reset");
        @(negedge clk); rst = 1'b1;
        cyc(3);
        check_all_zero("after_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pedestrian_request_unit.md
# pedestrian_request_unit

Pedestrian-side front end for `traffic_light_controller`: it synchronises and debounces four crossing push-buttons, latches pending requests onto the controller's `pedestrian[3:0]` input, and consumes the returned `pedestrian_grant`. On each grant it runs the walk / flashing-don't-walk lamp sequence for the served crossings. It also cross-checks `traffic_light`, and flags a conflict if the vehicle light is not red while pedestrians are walking.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, 16, consecutive stable synchronised samples required to change a debounced button state
- `WALK_CYCLES`, 20, duration of the steady walk phase
- `FLASH_CYCLES`, 10, duration of the flashing don't-walk phase
- `FLASH_PERIOD`, 2, cycles per `flash_lamp` toggle
- `MAX_WAIT`, 100, pending-request age that triggers timeout (only with `PRU_TIMEOUT_EN`)

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  asynchronous, active-low reset
- `btn`  in  4  raw push-buttons, asynchronous, active-high
- `traffic_light`  in  3  vehicle light from the controller (encoding in package)
- `pedestrian_grant`  in  1  grant from the controller
- `pedestrian`  out  4  pending request vector to the controller
- `served`  out  4  crossings served by the current walk cycle
- `walk_lamp`  out  1  steady walk indication
- `flash_lamp`  out  1  flashing don't-walk indication
- `busy`  out  1  high in WALK or FLASH
- `conflict`  out  1  sticky; the vehicle light was non-red during WALK/FLASH
- `wait_timeout`  out  1  sticky; a request aged past MAX_WAIT (tied 0 without `PRU_TIMEOUT_EN`)

## Operation
- Reset drives every output to 0, puts the FSM in IDLE, and clears all counters, synchronisers and debounced states.
- Each `btn` bit has a 2-flop synchroniser, then a per-bit debounce counter. The debounced state flips once the synchronised level has differed from it for DEBOUNCE_CYCLES consecutive cycles. Any glitch resets the counter.
- A rising edge of the debounced state sets the matching `pedestrian` bit. The bit stays set until it is served.
- FSM states:
  - IDLE: if `pedestrian_grant`=1 and `pedestrian`≠0, capture `served`←`pedestrian`, clear the served bits, and go to WALK. A grant with no pending request is ignored.
  - WALK: `walk_lamp`=1 for WALK_CYCLES cycles, then go to FLASH.
  - FLASH: `flash_lamp` starts at 1 and toggles every FLASH_PERIOD cycles for FLASH_CYCLES cycles. It then returns to IDLE with `served`←0 and `flash_lamp`←0.
- `pedestrian_grant` is ignored in WALK and FLASH.
- New button edges during WALK/FLASH set pending bits for the next service.
- If a button edge coincides with the grant-capture cycle, that bit stays pending for the next service; it is not cleared.
- `conflict` sets if `traffic_light`≠RED in any WALK/FLASH cycle. It is cleared only by reset.
- A mid-sequence reset abandons the sequence immediately and drops all lamps and pending requests.

## Timing
- Button-to-`pedestrian` latency: 2 synchroniser cycles + DEBOUNCE_CYCLES + 1 register cycle.
- Grant-to-WALK: `walk_lamp` and `busy` rise the cycle after the grant is sampled. `pedestrian` clears in that same cycle.
- WALK lasts exactly WALK_CYCLES cycles. FLASH lasts exactly FLASH_CYCLES cycles. `busy` is high for WALK_CYCLES+FLASH_CYCLES cycles in total.
- Counter widths are `$clog2(param+1)` each. Counters saturate and never wrap.

## Configuration
- `PRU_TIMEOUT_EN` defined:
  - each crossing has an age counter that runs while its `pedestrian` bit is set;
  - reaching MAX_WAIT sets `wait_timeout` (sticky until reset);
  - the counter clears when the bit is served.
- `PRU_TIMEOUT_EN` undefined: the age counters are not built and `wait_timeout` is tied to 0.

## Structure
- Shared package `traffic_pkg`: `traffic_light` encodings RED=3'b100, YELLOW=3'b010, GREEN=3'b001, and the `pru_state_t` enum {IDLE, WALK, FLASH}.
- Sub-module `pru_debounce`, instantiated 4×: one bit with synchroniser, counter, debounced level and rising-edge pulse.

## Test plan
Bench parameters: DEBOUNCE_CYCLES=4, WALK_CYCLES=6, FLASH_CYCLES=4, FLASH_PERIOD=2, MAX_WAIT=12.
- Reset: hold `rst`=0 with `btn`=4'hF → all outputs 0. Release reset → `pedestrian` still 0 before any debounce completes.
- Debounce: a 3-cycle pulse on `btn[0]` → `pedestrian`=0. A 5-cycle press → `pedestrian`=4'b0001, set 7 cycles after the press.
- Service: `pedestrian`=4'b0101, grant for 1 cycle, `traffic_light`=RED → next cycle `served`=4'b0101 and `pedestrian`=0. Then `walk_lamp` high for 6 cycles, then `flash_lamp` 1,1,0,0, then IDLE with `served`=0.
- Grant with `pedestrian`=0 → FSM stays in IDLE and `busy`=0.
- Press `btn[3]` during WALK → `pedestrian`=4'b1000, served only on the next grant. Set `traffic_light`=GREEN during FLASH → `conflict`=1, and it persists after the return to IDLE.
- With `PRU_TIMEOUT_EN`: leave `pedestrian[2]` ungranted for 12 cycles → `wait_timeout`=1. Without the macro → `wait_timeout` stays 0.
